// File: rtl/draw_cmd_sequencer_pkg.sv
// Shared definitions for the draw command sequencer: FSM encoding, descriptor
// word layout and the position of the triangle-count field inside ctrl1.
package draw_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_CHECK,
        ST_LAUNCH,
        ST_WAIT,
        ST_FINISH
    } seq_state_e;

    localparam int DESC_I_PTR = 0;
    localparam int DESC_V_PTR = 1;
    localparam int DESC_F_PTR = 2;
    localparam int DESC_CTRL0 = 3;
    localparam int DESC_CTRL1 = 4;
    localparam int DESC_RES   = 5;

    localparam int TRI_CNT_LSB   = 0;
    localparam int TRI_CNT_WIDTH = 16;

endpackage

// File: rtl/desc_fetch_unit.sv
// Reads one descriptor from main memory: issues DESC_WORDS back-to-back reads,
// tags returning data with a latency-matched valid pipe and lands it in shadow registers.
module desc_fetch_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_RD_LATENCY = 2,
    parameter int DESC_WORDS     = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_start_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                  issue_last_o,
    output logic                  fetch_done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] shadow_o [DESC_WORDS]
);

    localparam int CNT_W = (DESC_WORDS > 1) ? $clog2(DESC_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DESC_WORDS - 1);

    logic                      issuing_q, issuing_d;
    logic [CNT_W-1:0]          issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [MEM_RD_LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic                      land;

    assign mem_rd_en_o   = issuing_q;
    assign mem_rd_addr_o = issuing_q ? (base_q + ADDR_WIDTH'(issue_cnt_q)) : '0;
    assign issue_last_o  = issuing_q && (issue_cnt_q == CNT_LAST);
    assign land          = vld_q[MEM_RD_LATENCY-1];
    assign fetch_done_o  = land && (word_cnt_q == CNT_LAST);

    always_comb begin
        issuing_d   = issuing_q;
        issue_cnt_d = issue_cnt_q;
        base_d      = base_q;
        word_cnt_d  = word_cnt_q;
        // Bit 0 is the strobe just issued; the top bit marks data on the bus now.
        vld_d       = MEM_RD_LATENCY'({vld_q, issuing_q});
        if (fetch_start_i) begin
            issuing_d   = 1'b1;
            issue_cnt_d = '0;
            base_d      = fetch_addr_i;
            word_cnt_d  = '0;
        end else begin
            if (issuing_q) begin
                if (issue_cnt_q == CNT_LAST) begin
                    issuing_d = 1'b0;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            if (land) begin
                word_cnt_d = (word_cnt_q == CNT_LAST) ? '0 : word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issuing_q   <= 1'b0;
            issue_cnt_q <= '0;
            base_q      <= '0;
            vld_q       <= '0;
            word_cnt_q  <= '0;
        end else begin
            issuing_q   <= issuing_d;
            issue_cnt_q <= issue_cnt_d;
            base_q      <= base_d;
            vld_q       <= vld_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DESC_WORDS; gi++) begin : g_shadow
            logic [DATA_WIDTH-1:0] word_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    word_q <= '0;
                end else if (land && (word_cnt_q == CNT_W'(gi))) begin
                    word_q <= mem_rd_data_i;
                end
            end
            assign shadow_o[gi] = word_q;
        end
    endgenerate

endmodule

// File: rtl/draw_cmd_sequencer.sv
// Walks a list of draw descriptors, loading each into the rasteriser's instruction
// registers, starting it and waiting for completion; one list_done per list.
module draw_cmd_sequencer
    import draw_cmd_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int MAIN_MEM_ADDR_WIDTH = 32,
    parameter int MEM_RD_LATENCY      = 2,
    parameter int DESC_WORDS          = 6,
    parameter int DONE_TIMEOUT        = 2**20
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           go,
    input  logic                           abort,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] cmd_list_ptr,
    input  logic [15:0]                    num_cmds,
    output logic                           busy,
    output logic                           list_done,
    output logic                           error,
    output logic                           aborted,
    output logic [15:0]                    cmd_index,
    output logic [MAIN_MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                           mem_rd_en,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data,
    output logic                           rast_start,
    input  logic                           rast_ready,
    input  logic                           rast_done,
    output logic [DATA_WIDTH-1:0]          i_array_ptr,
    output logic [DATA_WIDTH-1:0]          v_array_ptr,
    output logic [DATA_WIDTH-1:0]          f_array_ptr,
    output logic [31:0]                    ctrl_reg0,
    output logic [31:0]                    ctrl_reg1,
    output logic [31:0]                    res_reg
);

    localparam int AW   = MAIN_MEM_ADDR_WIDTH;
    localparam int TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (DONE_TIMEOUT > 0) ? TO_W'(DONE_TIMEOUT - 1) : '0;

    seq_state_e       state_q, state_d;
    logic [AW-1:0]    base_q, base_d;
    logic [15:0]      num_q, num_d;
    logic [15:0]      idx_q, idx_d;
    logic             error_q, error_d;
    logic             aborted_q, aborted_d;
    logic             abort_seen_q, abort_seen_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             start_q, start_d;

    logic             fetch_start, issue_last, fetch_done, complete, launch_fire;
    logic [AW-1:0]    desc_addr;
    logic [DATA_WIDTH-1:0] shadow [DESC_WORDS];

    desc_fetch_unit #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (AW),
        .MEM_RD_LATENCY (MEM_RD_LATENCY),
        .DESC_WORDS     (DESC_WORDS)
    ) u_fetch (
        .clk           (clk),
        .reset         (reset),
        .fetch_start_i (fetch_start),
        .fetch_addr_i  (desc_addr),
        .issue_last_o  (issue_last),
        .fetch_done_o  (fetch_done),
        .mem_rd_en_o   (mem_rd_en),
        .mem_rd_addr_o (mem_rd_addr),
        .mem_rd_data_i (mem_rd_data),
        .shadow_o      (shadow)
    );

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign list_done   = (state_q == ST_FINISH);
    assign error       = error_q;
    assign aborted     = aborted_q;
    assign cmd_index   = idx_q;
    assign rast_start  = start_q;
    assign launch_fire = (state_q == ST_LAUNCH) && rast_ready;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        num_d        = num_q;
        idx_d        = idx_q;
        error_d      = error_q;
        aborted_d    = aborted_q;
        abort_seen_d = abort_seen_q | (abort & busy);
        to_cnt_d     = to_cnt_q;
        start_d      = 1'b0;
        fetch_start  = 1'b0;
        complete     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    base_d       = cmd_list_ptr;
                    num_d        = num_cmds;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    aborted_d    = 1'b0;
                    abort_seen_d = 1'b0;
                    if (num_cmds == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d     = ST_FETCH;
                        fetch_start = 1'b1;
                    end
                end
            end
            ST_FETCH:  if (issue_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (fetch_done) state_d = ST_CHECK;
            ST_CHECK: begin
                if (shadow[DESC_CTRL1][TRI_CNT_LSB +: TRI_CNT_WIDTH] == '0) begin
                    complete = 1'b1;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (rast_ready) begin
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done coincident with our own start pulse belongs to an earlier job.
                if (rast_done && !start_q) begin
                    complete = 1'b1;
                end else if ((DONE_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                    error_d = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (complete) begin
            idx_d = idx_q + 16'd1;
            if (idx_d == num_q) begin
                state_d = ST_FINISH;
            end else if (abort_seen_q || abort) begin
                aborted_d = 1'b1;
                state_d   = ST_FINISH;
            end else begin
                state_d     = ST_FETCH;
                fetch_start = 1'b1;
            end
        end

        desc_addr = base_d + (AW'(idx_d) * AW'(DESC_WORDS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            error_q      <= 1'b0;
            aborted_q    <= 1'b0;
            abort_seen_q <= 1'b0;
            to_cnt_q     <= '0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            error_q      <= error_d;
            aborted_q    <= aborted_d;
            abort_seen_q <= abort_seen_d;
            to_cnt_q     <= to_cnt_d;
            start_q      <= start_d;
        end
    end

    // Instruction outputs change together with the start pulse and hold until the next launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_array_ptr <= '0;
            v_array_ptr <= '0;
            f_array_ptr <= '0;
            ctrl_reg0   <= '0;
            ctrl_reg1   <= '0;
            res_reg     <= '0;
        end else if (launch_fire) begin
            i_array_ptr <= shadow[DESC_I_PTR];
            v_array_ptr <= shadow[DESC_V_PTR];
            f_array_ptr <= shadow[DESC_F_PTR];
            ctrl_reg0   <= 32'(shadow[DESC_CTRL0]);
            ctrl_reg1   <= 32'(shadow[DESC_CTRL1]);
            res_reg     <= 32'(shadow[DESC_RES]);
        end
    end

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Directed bench for draw_cmd_sequencer: latency-2 memory model, auto-responding
// rasteriser model and a linear sequence of list runs with hand-computed expectations.
module tb_draw_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset, go, abort;
    logic [31:0] cmd_list_ptr;
    logic [15:0] num_cmds;
    logic        busy, list_done, error, aborted;
    logic [15:0] cmd_index;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        rast_start, rast_ready;
    logic        rast_done = 1'b0;
    logic [31:0] i_array_ptr, v_array_ptr, f_array_ptr, ctrl_reg0, ctrl_reg1, res_reg;

    always #5 clk = ~clk;

    draw_cmd_sequencer #(
        .DATA_WIDTH          (32),
        .MAIN_MEM_ADDR_WIDTH (32),
        .MEM_RD_LATENCY      (2),
        .DESC_WORDS          (6),
        .DONE_TIMEOUT        (100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .abort        (abort),
        .cmd_list_ptr (cmd_list_ptr),
        .num_cmds     (num_cmds),
        .busy         (busy),
        .list_done    (list_done),
        .error        (error),
        .aborted      (aborted),
        .cmd_index    (cmd_index),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .rast_start   (rast_start),
        .rast_ready   (rast_ready),
        .rast_done    (rast_done),
        .i_array_ptr  (i_array_ptr),
        .v_array_ptr  (v_array_ptr),
        .f_array_ptr  (f_array_ptr),
        .ctrl_reg0    (ctrl_reg0),
        .ctrl_reg1    (ctrl_reg1),
        .res_reg      (res_reg)
    );

    // Memory: word at address a holds 0xD000_0000 | a unless overridden.
    logic [31:0] mem [0:4095];
    logic [31:0] p1_addr = '0, p2_addr = '0;
    always @(posedge clk) begin
        p1_addr <= mem_rd_addr;
        p2_addr <= p1_addr;
    end
    assign mem_rd_data = mem[p2_addr[11:0]];

    // Rasteriser: pulses done done_delay cycles after start; 0 means never.
    int   done_delay = 50;
    int   rast_cnt   = 0;
    logic rast_armed = 1'b0;
    always @(posedge clk) begin
        rast_done <= 1'b0;
        if (rast_start) begin
            rast_cnt   <= done_delay;
            rast_armed <= (done_delay != 0);
        end else if (rast_armed) begin
            if (rast_cnt <= 1) begin
                rast_done  <= 1'b1;
                rast_armed <= 1'b0;
            end else begin
                rast_cnt <= rast_cnt - 1;
            end
        end
    end

    int          start_cnt = 0;
    int          ldone_cnt = 0;
    logic [31:0] rd_log [$];
    always @(posedge clk) begin
        if (rast_start) start_cnt <= start_cnt + 1;
        if (list_done)  ldone_cnt <= ldone_cnt + 1;
        if (mem_rd_en)  rd_log.push_back(mem_rd_addr);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_go(input logic [31:0] ptr, input logic [15:0] n);
        @(negedge clk);
        cmd_list_ptr = ptr;
        num_cmds     = n;
        go           = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int k;
        bit seen;
        seen = 1'b0;
        for (k = 0; k < max_cycles; k++) begin
            if (list_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_list_done_seen"}, 32'(seen), 32'd1);
        $display("[TB] %s: list_done after %0d cycles, cmd_index=%0d error=%0b aborted=%0b",
                 tag, k, cmd_index, error, aborted);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, smark, lmark, k;
        bit found;

        for (int i = 0; i < 4096; i++) mem[i] = 32'hD000_0000 | 32'(i);
        mem[12'h20A] = 32'hABCD_0000;   // desc 1 of list at 0x200: zero triangles

        reset = 1'b1; go = 1'b0; abort = 1'b0; rast_ready = 1'b1;
        cmd_list_ptr = '0; num_cmds = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_list_done", 32'(list_done), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_rast_start", 32'(rast_start), 32'd0);
        check("rst_cmd_index", 32'(cmd_index), 32'd0);
        check("rst_i_array_ptr", i_array_ptr, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;

        // Two descriptors at 0x100; a second go while busy must be ignored.
        mark = rd_log.size(); smark = start_cnt; lmark = ldone_cnt;
        run_go(32'h100, 16'd2);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        cmd_list_ptr = 32'h800; num_cmds = 16'd5; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done("t1", 400);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("t1_read_count", 32'(rd_log.size() - mark), 32'd12);
        for (int i = 0; i < 12; i++) check("t1_rd_addr", rd_log[mark + i], 32'h100 + 32'(i));
        check("t1_starts", 32'(start_cnt - smark), 32'd2);
        check("t1_list_done_count", 32'(ldone_cnt - lmark), 32'd1);
        check("t1_list_done_pulse", 32'(list_done), 32'd0);
        check("t1_cmd_index", 32'(cmd_index), 32'd2);
        check("t1_i_array_ptr", i_array_ptr, 32'hD000_0106);
        check("t1_f_array_ptr", f_array_ptr, 32'hD000_0108);
        check("t1_res_reg", res_reg, 32'hD000_010B);

        // Three descriptors at 0x200, the middle one has zero triangles.
        smark = start_cnt;
        run_go(32'h200, 16'd3);
        wait_done("t2", 400);
        @(negedge clk);
        check("t2_starts", 32'(start_cnt - smark), 32'd2);
        check("t2_cmd_index", 32'(cmd_index), 32'd3);
        check("t2_i_array_ptr", i_array_ptr, 32'hD000_020C);
        check("t2_ctrl_reg1", ctrl_reg1, 32'hD000_0210);

        // rast_ready held low while sitting in LAUNCH.
        smark = start_cnt;
        rast_ready = 1'b0;
        run_go(32'h300, 16'd1);
        repeat (29) @(negedge clk);
        check("t3_no_start_yet", 32'(start_cnt - smark), 32'd0);
        check("t3_rast_start_low", 32'(rast_start), 32'd0);
        check("t3_outputs_held", i_array_ptr, 32'hD000_020C);
        check("t3_busy", 32'(busy), 32'd1);
        rast_ready = 1'b1;
        @(negedge clk);
        check("t3_rast_start", 32'(rast_start), 32'd1);
        check("t3_i_array_ptr", i_array_ptr, 32'hD000_0300);
        check("t3_ctrl_reg0", ctrl_reg0, 32'hD000_0303);
        @(negedge clk);
        check("t3_rast_start_1cyc", 32'(rast_start), 32'd0);
        wait_done("t3", 200);
        @(negedge clk);

        // Abort during WAIT of descriptor 0 of 4.
        mark = rd_log.size(); smark = start_cnt;
        run_go(32'h400, 16'd4);
        repeat (20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_still_busy", 32'(busy), 32'd1);
        wait_done("t4", 300);
        check("t4_aborted", 32'(aborted), 32'd1);
        check("t4_cmd_index", 32'(cmd_index), 32'd1);
        check("t4_error", 32'(error), 32'd0);
        @(negedge clk);
        check("t4_reads", 32'(rd_log.size() - mark), 32'd6);
        check("t4_starts", 32'(start_cnt - smark), 32'd1);

        // Timeout: rast_done never arrives.
        done_delay = 0;
        run_go(32'h500, 16'd1);
        check("t5_aborted_cleared", 32'(aborted), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rast_start) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_start_seen", 32'(found), 32'd1);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (list_done) break;
        end
        $display("[TB] t5: list_done %0d cycles after rast_start, error=%0b", k, error);
        check("t5_timeout_cycles", 32'(k), 32'd100);
        check("t5_error", 32'(error), 32'd1);
        check("t5_cmd_index", 32'(cmd_index), 32'd0);
        @(negedge clk);
        done_delay = 50;

        // Reset during the fourth read of a fetch, then a clean refetch.
        run_go(32'h600, 16'd1);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_en && (mem_rd_addr == 32'h603)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_word3_seen", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("t6_rst_mem_rd_addr", mem_rd_addr, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_error", 32'(error), 32'd0);
        check("t6_rst_i_array_ptr", i_array_ptr, 32'd0);
        cmd_list_ptr = 32'h700; num_cmds = 16'd1; go = 1'b1;
        @(negedge clk);
        reset = 1'b0; go = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_go_with_reset_ignored", 32'(busy), 32'd0);
        mark = rd_log.size(); smark = start_cnt;
        run_go(32'h600, 16'd1);
        wait_done("t6", 200);
        @(negedge clk);
        check("t6_reads", 32'(rd_log.size() - mark), 32'd6);
        check("t6_first_rd", rd_log[mark], 32'h600);
        check("t6_starts", 32'(start_cnt - smark), 32'd1);
        check("t6_i_array_ptr", i_array_ptr, 32'hD000_0600);
        check("t6_v_array_ptr", v_array_ptr, 32'hD000_0601);
        check("t6_res_reg", res_reg, 32'hD000_0605);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
